game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 44 ++++
 rtl/wishbone_if.sv | 13 +
 rtl/game_stats.sv | 42 ++++
 rtl/game_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types, register map and preset tables for the game controller
package game_pkg;

  typedef enum logic [2:0] {
    MENU      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    WIN       = 3'd4,
    LOST      = 3'd5,
    GAME_OVER = 3'd6
  } fsm_state_t;

  localparam int NUM_SETTINGS = 7;
  // Order: row/col, mines, timer seconds, field size, board size, xpos, ypos
  typedef logic [0:NUM_SETTINGS-1][15:0] settings_t;

  localparam logic [7:0] ADR_SET_LAST   = 8'h0C;
  localparam logic [7:0] ADR_WON        = 8'h0E;
  localparam logic [7:0] ADR_LOST       = 8'h10;
  localparam logic [7:0] ADR_STREAK     = 8'h12;
  localparam logic [7:0] ADR_BEST       = 8'h14;
  localparam logic [7:0] ADR_CTRL       = 8'h16;
  localparam logic [7:0] ADR_CUST_FIRST = 8'h18;
  localparam logic [7:0] ADR_CUST_LAST  = 8'h24;
  localparam logic [15:0] RD_UNMAPPED   = 16'hDEAD;

  localparam int PRESET_NUM = 3;
  localparam settings_t PRESETS [PRESET_NUM] = '{
    '{16'd9,  16'd10, 16'd999, 16'd16, 16'd144, 16'd100, 16'd50},
    '{16'd16, 16'd40, 16'd999, 16'd16, 16'd256, 16'd80,  16'd40},
    '{16'd24, 16'd99, 16'd999, 16'd16, 16'd384, 16'd40,  16'd20}
  };

  // Levels beyond the table fall back to the hardest preset
  function automatic settings_t preset_row(input int idx);
    settings_t r = PRESETS[PRESET_NUM-1];
    for (int i = 0; i < PRESET_NUM; i++) begin
      if (i == idx) r = PRESETS[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// rtl/wishbone_if.sv - register access bus, signal names seen from the master side
interface wishbone_if;
  logic        stb_o;
  logic        we_o;
  logic [7:0]  adr_o;
  logic [15:0] dat_o;
  logic [15:0] dat_i;
  logic        ack_i;
  logic        stall_i;

  modport slave  (input stb_o, we_o, adr_o, dat_o, output dat_i, ack_i, stall_i);
  modport master (output stb_o, we_o, adr_o, dat_o, input dat_i, ack_i, stall_i);
endinterface

// File: rtl/game_stats.sv
// rtl/game_stats.sv - saturating win/loss/streak counters with synchronous clear
module game_stats #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              win,
  input  logic              loss,
  output logic [STAT_W-1:0] won_cnt,
  output logic [STAT_W-1:0] lost_cnt,
  output logic [STAT_W-1:0] streak,
  output logic [STAT_W-1:0] best_streak
);

  localparam logic [STAT_W-1:0] CNT_MAX = '1;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + 1'b1;
  endfunction

  logic [STAT_W-1:0] streak_inc;
  assign streak_inc = sat_inc(streak);

  // Clear outranks a same-cycle win/loss update
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      won_cnt     <= '0;
      lost_cnt    <= '0;
      streak      <= '0;
      best_streak <= '0;
    end else if (win) begin
      won_cnt <= sat_inc(won_cnt);
      streak  <= streak_inc;
      if (streak_inc > best_streak) best_streak <= streak_inc;
    end else if (loss) begin
      lost_cnt <= sat_inc(lost_cnt);
      streak   <= '0;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game flow FSM with level settings, statistics and register bus
module game_ctrl
  import game_pkg::*;
#(
  parameter int  NUM_PRESETS = PRESET_NUM,
  parameter int  STAT_W      = 16,
  parameter bit  CUSTOM_EN   = 1'b1,
  localparam int LEVEL_W     = $clog2(NUM_PRESETS + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level,
  input  logic               timer_stop,
  input  logic               game_won,
  input  logic               game_lost,
  input  logic               retry,
  output logic [2:0]         state_out,
  wishbone_if.slave          game_settings
);

  fsm_state_t        state, state_nxt;
  settings_t         active, custom;
  logic [LEVEL_W-1:0] lvl_q;
  logic [STAT_W-1:0] won_cnt, lost_cnt, streak, best_streak;
  logic              level_ok, stall, acc, wr, clr_stats, is_cust, cust_wr_ok;
  logic [7:0]        adr, cofs;
  logic [15:0]       rd_data;

  assign state_out = state;
  assign adr       = game_settings.adr_o;
  assign cofs      = adr - ADR_CUST_FIRST;

  assign level_ok = (level != '0) &&
                    ((int'(level) <= NUM_PRESETS) ||
                     (CUSTOM_EN && (int'(level) == NUM_PRESETS + 1)));

  always_ff @(posedge clk) begin
    if (rst) state <= MENU;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MENU:      if (level_ok) state_nxt = LOAD;
      LOAD:      state_nxt = PLAY;
      PLAY: begin
        if (timer_stop)     state_nxt = PAUSE;
        else if (game_won)  state_nxt = WIN;
        else if (game_lost) state_nxt = LOST;
      end
      PAUSE:     if (!timer_stop) state_nxt = PLAY;
      WIN, LOST: state_nxt = GAME_OVER;
      GAME_OVER: if (retry) state_nxt = MENU;
      default:   state_nxt = MENU;
    endcase
  end

  // The level input need not be held past MENU, so remember it for LOAD
  always_ff @(posedge clk) begin
    if (rst)                          lvl_q <= '0;
    else if (state == MENU && level_ok) lvl_q <= level;
  end

  always_ff @(posedge clk) begin
    if (rst || (state == GAME_OVER && retry)) begin
      active <= '0;
    end else if (state == LOAD) begin
      if (CUSTOM_EN && int'(lvl_q) == NUM_PRESETS + 1) active <= custom;
      else                                              active <= preset_row(int'(lvl_q) - 1);
    end
  end

  assign stall      = (state == LOAD);
  assign acc        = game_settings.stb_o && !stall;
  assign wr         = acc && game_settings.we_o;
  assign clr_stats  = wr && (adr == ADR_CTRL) && game_settings.dat_o[0];
  assign is_cust    = CUSTOM_EN && !adr[0] && (adr >= ADR_CUST_FIRST) && (adr <= ADR_CUST_LAST);
  assign cust_wr_ok = wr && is_cust && (state == MENU || state == GAME_OVER);

  always_ff @(posedge clk) begin
    if (rst)             custom <= '0;
    else if (cust_wr_ok) custom[cofs[3:1]] <= game_settings.dat_o;
  end

  always_comb begin
    rd_data = RD_UNMAPPED;
    if (!adr[0]) begin
      if (adr <= ADR_SET_LAST) rd_data = active[adr[3:1]];
      else if (is_cust)        rd_data = custom[cofs[3:1]];
      else begin
        case (adr)
          ADR_WON:    rd_data = 16'(won_cnt);
          ADR_LOST:   rd_data = 16'(lost_cnt);
          ADR_STREAK: rd_data = 16'(streak);
          ADR_BEST:   rd_data = 16'(best_streak);
          default:    rd_data = RD_UNMAPPED;
        endcase
      end
    end
  end

  // Read data is captured at acceptance, so same-cycle counter updates are not seen
  always_ff @(posedge clk) begin
    if (rst) begin
      game_settings.ack_i <= 1'b0;
      game_settings.dat_i <= '0;
    end else begin
      game_settings.ack_i <= acc;
      game_settings.dat_i <= (acc && !game_settings.we_o) ? rd_data : 16'h0;
    end
  end

  assign game_settings.stall_i = stall;

  game_stats #(.STAT_W(STAT_W)) u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr_stats),
    .win         (state == WIN),
    .loss        (state == LOST),
    .won_cnt     (won_cnt),
    .lost_cnt    (lost_cnt),
    .streak      (streak),
    .best_streak (best_streak)
  );

endmodule
